// File: rtl/mac8_pkg.sv
// Shared types and constants for the mac8 dot-product sequencer and its accumulator.
package mac8_pkg;

  localparam int DIN_W = 8;
  localparam int ACC_W = 16;

  // Fixed encodings keep the state values stable for older tools and waveform scripts.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

  localparam state_e           STATE_RST = IDLE;
  localparam logic [ACC_W-1:0] ACC_RST   = '0;
  localparam logic             FLAG_RST  = 1'b0;

endpackage

// File: rtl/mac8_seq_if.sv
// Command, operand and result signals of the mac8 sequencer.
// The master modport is the job owner; the slave modport is the sequencer.
interface mac8_seq_if #(
  parameter int LEN_W = 4
);
  import mac8_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [DIN_W-1:0] din0;
  logic [DIN_W-1:0] din1;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] dout;
  logic             ovf;

  modport master (
    output start, len, in_valid, din0, din1, out_ready,
    input  busy, in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  start, len, in_valid, din0, din1, out_ready,
    output busy, in_ready, out_valid, dout, ovf
  );

endinterface

// File: rtl/mac8_acc.sv
// 8x8 unsigned multiplier feeding a wrapping 16-bit accumulator.
// The carry out of each accumulation is reported combinationally for the caller's sticky flag.
module mac8_acc
  import mac8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din0,
  input  logic [DIN_W-1:0] din1,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W-1:0] prod;
  logic [ACC_W:0]   sum;

  assign prod  = {{(ACC_W-DIN_W){1'b0}}, din0} * {{(ACC_W-DIN_W){1'b0}}, din1};
  assign sum   = {1'b0, acc} + {1'b0, prod};
  assign carry = en & sum[ACC_W];

  // Clear wins over enable so that a new job never inherits a stale sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= ACC_RST;
    end else if (clr) begin
      acc <= ACC_RST;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac8_seq.sv
// Dot-product sequencer: takes a start/len command, streams len operand pairs into
// mac8_acc and presents the 16-bit sum with a sticky overflow flag.
module mac8_seq
  import mac8_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  mac8_seq_if.slave bus
);

  state_e           state;
  state_e           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             ovf_q;
  logic             accept_start;
  logic             hs_in;
  logic             last_pair;
  logic             carry;
  logic [ACC_W-1:0] acc;

  assign accept_start = (state == IDLE) & bus.start;
  assign hs_in        = (state == RUN) & bus.in_valid;
  assign last_pair    = hs_in & (cnt == LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : RUN;
      RUN:     if (last_pair) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STATE_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept_start) begin
      cnt <= bus.len;
    end else if (hs_in) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  // Overflow is sticky across the job and only cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= FLAG_RST;
    end else if (accept_start) begin
      ovf_q <= 1'b0;
    end else if (carry) begin
      ovf_q <= 1'b1;
    end
  end

  mac8_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_start),
    .en    (hs_in),
    .din0  (bus.din0),
    .din1  (bus.din1),
    .acc   (acc),
    .carry (carry)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.dout      = acc;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac8_seq.sv
// Directed bench for mac8_seq: a job-level integer model is compared against the DUT
// every cycle, and literal expectations pin results, latencies and handshake counts.
module tb_mac8_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mac8_seq_if #(.LEN_W(4)) bus ();

  mac8_seq #(.LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int start_cyc;

  // Job-level model: a job is either collecting pairs or showing its result.
  bit     m_active = 1'b0;
  bit     m_show   = 1'b0;
  int     m_left   = 0;
  longint m_sum    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rst && bus.in_valid && bus.in_ready) hs_count <= hs_count + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_show   <= 1'b0;
      m_left   <= 0;
      m_sum    <= 0;
    end else if (m_active) begin
      if (bus.in_valid) begin
        m_sum  <= m_sum + longint'(bus.din0) * longint'(bus.din1);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_show   <= 1'b1;
        end
      end
    end else if (m_show) begin
      if (bus.out_ready) m_show <= 1'b0;
    end else if (bus.start) begin
      m_sum <= 0;
      if (bus.len == 0) begin
        m_show <= 1'b1;
      end else begin
        m_active <= 1'b1;
        m_left   <= int'(bus.len);
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_busy",      bus.busy,      longint'(m_active | m_show));
    checkOutput("model_in_ready",  bus.in_ready,  longint'(m_active));
    checkOutput("model_out_valid", bus.out_valid, longint'(m_show));
    checkOutput("model_dout",      bus.dout,      m_sum % 65536);
    checkOutput("model_ovf",       bus.ovf,       longint'(m_sum >= 65536));
  end

  task automatic applyStart(input int l);
    bus.start = 1'b1;
    bus.len   = 4'(l);
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic applyPair(input int a, input int b, input int gap);
    int k = 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.din0     = 8'(a);
    bus.din1     = 8'(b);
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("wait_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult();
    int k = 0;
    while (!bus.out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("wait_out_valid", bus.out_valid, 1);
  endtask

  initial begin
    int hs_base;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dout", bus.dout, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic job");
    applyStart(4);
    checkOutput("basic_in_ready_T1", bus.in_ready, 1);
    applyPair(4, 3, 0);
    applyPair(4, 3, 0);
    applyPair(4, 7, 0);
    applyPair(4, 7, 0);
    waitResult();
    checkOutput("basic_latency", cyc - start_cyc, 5);
    checkOutput("basic_dout", bus.dout, 80);
    checkOutput("basic_ovf", bus.ovf, 0);
    @(posedge clk); #1;

    $display("[TB] input backpressure");
    hs_base = hs_count;
    applyStart(4);
    applyPair(4, 3, 2);
    applyPair(4, 3, 2);
    applyPair(4, 7, 2);
    applyPair(4, 7, 2);
    waitResult();
    checkOutput("bp_latency", cyc - start_cyc, 13);
    checkOutput("bp_handshakes", hs_count - hs_base, 4);
    checkOutput("bp_dout", bus.dout, 80);
    @(posedge clk); #1;

    $display("[TB] zero length with output stall");
    bus.out_ready = 1'b0;
    applyStart(0);
    checkOutput("zero_latency", cyc - start_cyc, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("zero_out_valid_held", bus.out_valid, 1);
      checkOutput("zero_dout_held", bus.dout, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("zero_idle_busy", bus.busy, 0);
    checkOutput("zero_idle_out_valid", bus.out_valid, 0);

    $display("[TB] overflow");
    applyStart(2);
    applyPair(255, 255, 0);
    applyPair(255, 255, 0);
    waitResult();
    checkOutput("ovf_dout", bus.dout, 64514);
    checkOutput("ovf_flag", bus.ovf, 1);
    @(posedge clk); #1;
    checkOutput("ovf_dout_kept_idle", bus.dout, 64514);
    checkOutput("ovf_flag_kept_idle", bus.ovf, 1);
    applyStart(1);
    checkOutput("ovf_cleared_by_start", bus.ovf, 0);
    applyPair(2, 3, 0);
    waitResult();
    checkOutput("next_dout", bus.dout, 6);
    checkOutput("next_ovf", bus.ovf, 0);
    @(posedge clk); #1;

    $display("[TB] ignored start");
    applyStart(2);
    applyPair(1, 2, 0);
    bus.start = 1'b1;
    bus.len   = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    applyPair(3, 4, 0);
    waitResult();
    checkOutput("ign_dout", bus.dout, 14);
    @(posedge clk); #1;
    checkOutput("ign_idle_busy", bus.busy, 0);
    @(posedge clk); #1;
    checkOutput("ign_not_queued", bus.busy, 0);

    $display("[TB] reset mid-job");
    applyStart(4);
    applyPair(1, 1, 0);
    applyPair(2, 2, 0);
    checkOutput("pre_reset_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_dout", bus.dout, 0);
    checkOutput("mid_reset_busy", bus.busy, 0);
    checkOutput("mid_reset_in_ready", bus.in_ready, 0);
    checkOutput("mid_reset_out_valid", bus.out_valid, 0);
    checkOutput("mid_reset_ovf", bus.ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    applyStart(1);
    applyPair(5, 5, 0);
    waitResult();
    checkOutput("post_reset_latency", cyc - start_cyc, 2);
    checkOutput("post_reset_dout", bus.dout, 25);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac8_seq.md
# mac8_seq

Dot-product sequencer for the 8-bit multiply-accumulate datapath. It accepts a start command with a vector length, streams that many operand pairs through a valid/ready handshake, and accumulates their unsigned products into a 16-bit result. It then presents the result on a valid/ready output port. The block sits between an operand source (memory reader or host FIFO) and the result consumer, and it owns accumulator clearing so that consecutive dot products never share state.

## Interface
- `LEN_W`, default 4: width of the vector-length field; maximum length is 2^LEN_W−1.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `len` in LEN_W: number of operand pairs; sampled together with `start`.
- `busy` out 1: high in RUN and DONE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts the pair this cycle.
- `din0` in 8: unsigned operand A.
- `din1` in 8: unsigned operand B.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `dout` out 16: accumulated result.
- `ovf` out 1: sticky flag; set when any accumulation in the current job carried out of bit 15.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The state is registered.
- **IDLE**
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - On `start`=1 with `len`≠0: clear acc and `ovf`, load cnt=`len`, go to RUN.
  - On `start`=1 with `len`=0: clear acc and `ovf`, go directly to DONE (result 0).
- **RUN**
  - `in_ready`=1.
  - On each handshake (`in_valid`&`in_ready`): acc ← acc + din0·din1 and cnt ← cnt−1.
  - The product is 16-bit unsigned. The sum wraps modulo 2^16. A carry out sets `ovf`.
  - On the handshake where cnt=1, go to DONE.
  - With `in_valid`=0 the block holds all state. There is no timeout.
- **DONE**
  - `out_valid`=1; `dout` shows acc, held stable.
  - On `out_ready`=1, go to IDLE.
  - `dout` and `ovf` keep their values until the next accepted `start` clears them.
- `start` is ignored in RUN and DONE and is not queued.
- `dout` is the accumulator register itself, so there is no combinational path from the operand inputs to `dout`.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, acc=0, cnt=0, `ovf`=0, `busy`=0, `in_ready`=0, `out_valid`=0, `dout`=0. All of these hold while `rst` is low.
- Reset mid-job: the job is aborted immediately and no partial result is presented.
- `start` is sampled at cycle T. `in_ready` is high from T+1.
- Throughput is one pair per cycle.
- The last pair is accepted at edge E. `out_valid` and the final `dout` appear in the cycle following E.
- Minimum latency from `start` to `out_valid` is `len`+1 cycles.
- `len`=0: `out_valid` is high at T+1.
- The earliest next `start` is sampled in the cycle after the `out_valid`&`out_ready` handshake. This gives one IDLE cycle between jobs.
- `out_valid` never drops without a handshake. `dout` is stable while `out_valid`=1.
- All outputs are registered or decoded from the registered state only.

## Structure
- Shared package `mac8_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `DIN_W`=8 and `ACC_W`=16;
  - the reset-value constants.
- Sub-module `mac8_acc` is the 8×8 multiplier plus 16-bit accumulator.
  - Inputs: `clr` (synchronous), `en`, `din0`, `din1`.
  - Outputs: `acc` and `carry`.
- `mac8_seq` contains the FSM, the length counter, the handshake logic and the `ovf` flag.

## Test plan
- **Basic job:** `len`=4 with pairs (4,3),(4,3),(4,7),(4,7), `in_valid` continuously high, `out_ready`=1 → `out_valid` 5 cycles after `start`, `dout`=80, `ovf`=0.
- **Input backpressure:** same job with `in_valid` low for 2 cycles between every pair → `dout`=80, exactly 4 handshakes counted, `out_valid` only after the 4th.
- **Zero length and output stall:** `len`=0 → `out_valid` at T+1, `dout`=0. Then hold `out_ready`=0 for 3 cycles → `out_valid` and `dout` stable for those cycles, IDLE the cycle after `out_ready`=1.
- **Overflow:** `len`=2 with pairs (255,255) twice → `dout`=64514 (130050 mod 65536), `ovf`=1. The next job `len`=1 with (2,3) → `dout`=6, `ovf`=0.
- **Ignored start:** pulse `start` with `len`=3 while in RUN of a `len`=2 job → the current job completes normally and the spurious start has no effect.
- **Reset mid-job:** pull `rst` low after the 2nd pair of a `len`=4 job → all outputs 0 immediately. After release, a fresh `len`=1 job with (5,5) → `dout`=25.
